// File: rtl/botoes_filtro.sv
// botoes_filtro: conditions the decoded gamepad word once per video frame.
// The v_sync falling edge is turned into a single Clock50 tick. Each button is
// debounced across consecutive frame samples. The block produces a clean
// level per button, plus one-cycle press, release and auto-repeat pulses.
// No handshake is used: Entradas is a free-running level. It is only looked at
// in the cycle where FrameTick is high, so changes between ticks are ignored.
module botoes_filtro #(
    parameter int unsigned N_BOTOES     = 12,
    parameter int unsigned ESTAVEL      = 3,
    parameter int unsigned REPEAT_EN    = 1,
    parameter int unsigned REPEAT_DELAY = 30,
    parameter int unsigned REPEAT_RATE  = 6
) (
    input  logic                Clock50,
    input  logic                Reset,
    input  logic [N_BOTOES-1:0] Entradas,
    input  logic                v_sync,
    output logic [N_BOTOES-1:0] Estado,
    output logic [N_BOTOES-1:0] Pulso,
    output logic [N_BOTOES-1:0] Solto,
    output logic                FrameTick
);

    localparam int unsigned SW = $clog2(ESTAVEL) + 1;
    localparam int unsigned RW = $clog2(REPEAT_DELAY) + 1;

    localparam logic [SW-1:0] STAB_MAX   = SW'(ESTAVEL - 1);
    localparam logic [RW-1:0] REP_MAX    = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);

    // v_sync synchronizer and edge history; all idle high
    logic sync1, sync2, hist;

    // per-button counters
    logic [SW-1:0] stab   [N_BOTOES];
    logic [SW-1:0] stab_n [N_BOTOES];
    logic [RW-1:0] rep    [N_BOTOES];
    logic [RW-1:0] rep_n  [N_BOTOES];

    logic [N_BOTOES-1:0] estado_n;
    logic [N_BOTOES-1:0] pulso_n;
    logic [N_BOTOES-1:0] solto_n;
    logic [RW-1:0]       rep_inc;

    // synchronize v_sync and register a one-cycle tick on its falling edge
    always_ff @(posedge Clock50) begin
        if (Reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            hist      <= 1'b1;
            FrameTick <= 1'b0;
        end else begin
            sync1     <= v_sync;
            sync2     <= sync1;
            hist      <= sync2;
            FrameTick <= hist & ~sync2;
        end
    end

    // per-bit debounce, edge detection and auto-repeat, evaluated only on ticks
    always_comb begin
        estado_n = Estado;
        pulso_n  = '0;
        solto_n  = '0;
        stab_n   = stab;
        rep_n    = rep;
        rep_inc  = '0;
        if (FrameTick) begin
            for (int i = 0; i < int'(N_BOTOES); i++) begin
                // a level flips only after ESTAVEL differing samples in a row
                if (Entradas[i] == Estado[i]) begin
                    stab_n[i] = '0;
                end else if (stab[i] == STAB_MAX) begin
                    stab_n[i]   = '0;
                    estado_n[i] = ~Estado[i];
                end else begin
                    stab_n[i] = stab[i] + 1'b1;
                end

                if (estado_n[i] && !Estado[i]) begin
                    pulso_n[i] = 1'b1;
                    rep_n[i]   = '0;
                end else if (!estado_n[i] && Estado[i]) begin
                    // a release tick never emits a repeat
                    solto_n[i] = 1'b1;
                    rep_n[i]   = '0;
                end else if (Estado[i] && (REPEAT_EN != 0)) begin
                    // reload below the delay so later repeats come every REPEAT_RATE ticks
                    rep_inc = rep[i] + 1'b1;
                    if (rep_inc == REP_MAX) begin
                        pulso_n[i] = 1'b1;
                        rep_n[i]   = REP_RELOAD;
                    end else begin
                        rep_n[i] = rep_inc;
                    end
                end
            end
        end
    end

    // register debounced levels, pulses and counters
    always_ff @(posedge Clock50) begin
        if (Reset) begin
            Estado <= '0;
            Pulso  <= '0;
            Solto  <= '0;
            for (int i = 0; i < int'(N_BOTOES); i++) begin
                stab[i] <= '0;
                rep[i]  <= '0;
            end
        end else begin
            Estado <= estado_n;
            Pulso  <= pulso_n;
            Solto  <= solto_n;
            for (int i = 0; i < int'(N_BOTOES); i++) begin
                stab[i] <= stab_n[i];
                rep[i]  <= rep_n[i];
            end
        end
    end

endmodule

// File: tb/tb_botoes_filtro.sv
// tb_botoes_filtro: directed bench for botoes_filtro. It drives frame ticks
// through v_sync and queues the expected {Estado, Pulso, Solto} for the cycle
// after each tick. Entradas is randomly scrambled between ticks.
module tb_botoes_filtro;

    logic        clk;
    logic        rst;
    logic [11:0] entradas;
    logic        v_sync;
    logic [11:0] estado;
    logic [11:0] pulso;
    logic [11:0] solto;
    logic        frame_tick;

    logic [35:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    botoes_filtro dut (
        .Clock50   (clk),
        .Reset     (rst),
        .Entradas  (entradas),
        .v_sync    (v_sync),
        .Estado    (estado),
        .Pulso     (pulso),
        .Solto     (solto),
        .FrameTick (frame_tick)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_estado"}, estado, 12'h000);
        chk({tag, "_pulso"},  pulso,  12'h000);
        chk({tag, "_solto"},  solto,  12'h000);
        chk({tag, "_tick"},   {11'b0, frame_tick}, 12'h000);
    endtask

    // One frame: present ent, drop v_sync, and expect the given values in the cycle after the tick.
    task automatic do_tick(input string tag, input logic [11:0] ent,
                           input logic [11:0] e_est, input logic [11:0] e_pul,
                           input logic [11:0] e_sol);
        logic [35:0] e;
        int          lat;
        bit          got;
        exp_q.push_back({e_est, e_pul, e_sol});
        entradas = ent;
        @(negedge clk);
        v_sync = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (frame_tick) got = 1'b1;
        end
        chk({tag, "_tick_seen"}, {11'b0, got}, 12'h001);
        if (!got) begin
            $display("FAIL %s: no FrameTick within 8 cycles", tag);
            bad++;
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "tick timeout");
        end
        total++;
        assert (lat >= 3 && lat <= 4) else begin
            bad++;
            $error("FAIL %s_latency: observed=%0d expected=3..4", tag, lat);
        end
        v_sync = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, "_estado"}, estado, e[35:24]);
        chk({tag, "_pulso"},  pulso,  e[23:12]);
        chk({tag, "_solto"},  solto,  e[11:0]);
        chk({tag, "_tick_once"}, {11'b0, frame_tick}, 12'h000);
        // between ticks: scramble the inputs, which must have no effect
        for (int k = 0; k < 4; k++) begin
            entradas = 12'($urandom_range(0, 4095));
            @(negedge clk);
            chk({tag, "_idle_pulso"},  pulso,  12'h000);
            chk({tag, "_idle_solto"},  solto,  12'h000);
            chk({tag, "_idle_estado"}, estado, e_est);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero({tag, "_in_reset"});
        @(negedge clk);
        chk_all_zero({tag, "_in_reset2"});
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_all_zero({tag, "_after_reset"});
        end
    endtask

    // directed sequence
    initial begin
        rst      = 1'b1;
        v_sync   = 1'b1;
        entradas = 12'h000;
        repeat (3) @(negedge clk);

        // 1: reset, no spurious tick, first tick latency
        do_reset("t1");
        do_tick("t1_first", 12'h000, 12'h000, 12'h000, 12'h000);

        // 2: single press needs 3 ticks, then release
        do_tick("t2_p1", 12'h001, 12'h000, 12'h000, 12'h000);
        do_tick("t2_p2", 12'h001, 12'h000, 12'h000, 12'h000);
        do_tick("t2_p3", 12'h001, 12'h001, 12'h001, 12'h000);
        do_tick("t2_r1", 12'h000, 12'h001, 12'h000, 12'h000);
        do_tick("t2_r2", 12'h000, 12'h001, 12'h000, 12'h000);
        do_tick("t2_r3", 12'h000, 12'h000, 12'h000, 12'h001);

        // 3: bounce 1,1,0,1,1,1 on bit 0
        do_tick("t3_b1", 12'h001, 12'h000, 12'h000, 12'h000);
        do_tick("t3_b2", 12'h001, 12'h000, 12'h000, 12'h000);
        do_tick("t3_b3", 12'h000, 12'h000, 12'h000, 12'h000);
        do_tick("t3_b4", 12'h001, 12'h000, 12'h000, 12'h000);
        do_tick("t3_b5", 12'h001, 12'h000, 12'h000, 12'h000);
        do_tick("t3_b6", 12'h001, 12'h001, 12'h001, 12'h000);
        do_tick("t3_r1", 12'h000, 12'h001, 12'h000, 12'h000);
        do_tick("t3_r2", 12'h000, 12'h001, 12'h000, 12'h000);
        do_tick("t3_r3", 12'h000, 12'h000, 12'h000, 12'h001);

        // 5: bits 0 and 11 together
        do_tick("t5_p1", 12'h801, 12'h000, 12'h000, 12'h000);
        do_tick("t5_p2", 12'h801, 12'h000, 12'h000, 12'h000);
        do_tick("t5_p3", 12'h801, 12'h801, 12'h801, 12'h000);
        do_tick("t5_r1", 12'h000, 12'h801, 12'h000, 12'h000);
        do_tick("t5_r2", 12'h000, 12'h801, 12'h000, 12'h000);
        do_tick("t5_r3", 12'h000, 12'h000, 12'h000, 12'h801);

        // 4: hold bit 4, repeats at P+30, P+36, P+42, then release
        do_tick("t4_p1", 12'h010, 12'h000, 12'h000, 12'h000);
        do_tick("t4_p2", 12'h010, 12'h000, 12'h000, 12'h000);
        do_tick("t4_p3", 12'h010, 12'h010, 12'h010, 12'h000);
        for (int k = 1; k <= 44; k++) begin
            do_tick($sformatf("t4_hold%0d", k), 12'h010, 12'h010,
                    (k == 30 || k == 36 || k == 42) ? 12'h010 : 12'h000, 12'h000);
        end
        do_tick("t4_r1", 12'h000, 12'h010, 12'h000, 12'h000);
        do_tick("t4_r2", 12'h000, 12'h010, 12'h000, 12'h000);
        do_tick("t4_r3", 12'h000, 12'h000, 12'h000, 12'h010);
        do_tick("t4_after", 12'h000, 12'h000, 12'h000, 12'h000);

        // 6: reset at repeat count 20 while held
        do_tick("t6_p1", 12'h010, 12'h000, 12'h000, 12'h000);
        do_tick("t6_p2", 12'h010, 12'h000, 12'h000, 12'h000);
        do_tick("t6_p3", 12'h010, 12'h010, 12'h010, 12'h000);
        for (int k = 1; k <= 20; k++) begin
            do_tick($sformatf("t6_hold%0d", k), 12'h010, 12'h010, 12'h000, 12'h000);
        end
        entradas = 12'h010;
        do_reset("t6");
        do_tick("t6_q1", 12'h010, 12'h000, 12'h000, 12'h000);
        do_tick("t6_q2", 12'h010, 12'h000, 12'h000, 12'h000);
        do_tick("t6_q3", 12'h010, 12'h010, 12'h010, 12'h000);
        for (int k = 1; k <= 30; k++) begin
            do_tick($sformatf("t6_rehold%0d", k), 12'h010, 12'h010,
                    (k == 30) ? 12'h010 : 12'h000, 12'h000);
        end
        do_tick("t6_r1", 12'h000, 12'h010, 12'h000, 12'h000);
        do_tick("t6_r2", 12'h000, 12'h010, 12'h000, 12'h000);
        do_tick("t6_r3", 12'h000, 12'h000, 12'h000, 12'h010);

        chk("queue_empty", 12'(exp_q.size()), 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
